// File: rtl/hc_scale_seq_pkg.sv
// Shared definitions for the hyperbolic CORDIC front end: operand geometry,
// sequencer state and the microcode word for the constant-scale sequencer.
package hyperCord_pkg;

    localparam int I_SIGN_WIDTH = 1;
    localparam int I_INT_WIDTH  = 3;
    localparam int I_FRA_WIDTH  = 12;
    localparam int IDWIDTH      = I_SIGN_WIDTH + I_INT_WIDTH + I_FRA_WIDTH;

    localparam int SINH_STEPS = 4;
    localparam int COSH_STEPS = 3;
    localparam int SHW        = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {SRC_X, SRC_A, SRC_B} src_t;
    typedef enum logic {DST_A, DST_B} dst_t;

    typedef struct packed {
        src_t           srcA;
        logic [SHW-1:0] shA;
        src_t           srcB;
        logic [SHW-1:0] shB;
        dst_t           dst;
        logic           last;
    } ucode_t;

endpackage

// File: rtl/fixedAddSub.sv
// Fixed-point adder/subtractor; MODE=0 adds, otherwise subtracts. Wraps at DWIDTH.
module fixedAddSub #(
    parameter int DWIDTH = 16,
    parameter int MODE   = 0
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] y
);

    assign y = (MODE == 0) ? (a + b) : (a - b);

endmodule

// File: rtl/hc_scale_ucode.sv
// Microcode ROM: (sel, step) -> adder operand sources, shifts and destination
// for the sinh(0.5) / cosh(0.5) shift-add programs.
module hc_scale_ucode
    import hyperCord_pkg::*;
(
    input  logic       sel,
    input  logic [1:0] step,
    output ucode_t     uw
);

    always_comb begin
        uw = '{srcA: SRC_X, shA: '0, srcB: SRC_X, shB: '0, dst: DST_A, last: 1'b0};
        if (!sel) begin
            case (step)
                2'd0: uw.shB = 4'd2;
                2'd1: begin
                    uw.srcA = SRC_A; uw.shA = 4'd4;
                    uw.shB  = 4'd6;  uw.dst = DST_B;
                end
                2'd2: begin
                    uw.srcA = SRC_A; uw.srcB = SRC_B;
                end
                default: begin
                    uw.srcA = SRC_A; uw.shA = 4'd5;
                end
            endcase
        end else begin
            case (step)
                2'd0: uw.shB = 4'd3;
                2'd1: begin
                    uw.shA = 4'd9; uw.shB = 4'd11; uw.dst = DST_B;
                end
                default: begin
                    uw.srcA = SRC_A; uw.srcB = SRC_B;
                end
            endcase
        end
        uw.last = sel ? (step == 2'(COSH_STEPS - 1)) : (step == 2'(SINH_STEPS - 1));
    end

endmodule

// File: rtl/hc_scale_seq.sv
// Multi-cycle sinh(0.5)/cosh(0.5) constant multiplier: one shift-add step per
// cycle through a single shared adder, valid/ready on both sides.
module hc_scale_seq
    import hyperCord_pkg::*;
#(
    parameter int INT_WIDTH  = I_INT_WIDTH,
    parameter int FRA_WIDTH  = I_FRA_WIDTH,
    parameter int SIGN_WIDTH = I_SIGN_WIDTH,
    parameter int DWIDTH     = IDWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_sel,
    output logic              busy
);

    if (SIGN_WIDTH + INT_WIDTH + FRA_WIDTH != DWIDTH) begin : g_width_chk
        $error("hc_scale_seq: SIGN_WIDTH+INT_WIDTH+FRA_WIDTH must equal DWIDTH");
    end

    state_t state, state_nxt;
    logic [1:0] step;
    logic sel_q;
    logic signed [DWIDTH-1:0] x_r, a_r, b_r;
    logic signed [DWIDTH-1:0] va, vb, opa, opb, sum;
    ucode_t uw;

    hc_scale_ucode u_ucode (.sel(sel_q), .step(step), .uw(uw));

    always_comb begin
        va = x_r;
        vb = x_r;
        case (uw.srcA)
            SRC_A:   va = a_r;
            SRC_B:   va = b_r;
            default: va = x_r;
        endcase
        case (uw.srcB)
            SRC_A:   vb = a_r;
            SRC_B:   vb = b_r;
            default: vb = x_r;
        endcase
    end

    assign opa = va >>> uw.shA;
    assign opb = vb >>> uw.shB;

    fixedAddSub #(.DWIDTH(DWIDTH), .MODE(0)) u_add (.a(opa), .b(opb), .y(sum));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (uw.last)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step      <= '0;
            sel_q     <= 1'b0;
            x_r       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_r   <= in_data;
                    sel_q <= in_sel;
                    step  <= '0;
                end
                RUN: begin
                    if (uw.dst == DST_A) a_r <= sum;
                    else                 b_r <= sum;
                    if (uw.last) begin
                        // sinh chain carries an extra factor of two, dropped here
                        out_data  <= sel_q ? sum : (sum >>> 1);
                        out_sel   <= sel_q;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_hc_scale_seq.sv
// Scoreboard bench for hc_scale_seq: driver pushes expected results at accept,
// monitor pops and compares whenever a result is presented.
module tb_hc_scale_seq;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_sel = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, out_sel, busy;
    logic [15:0] out_data;

    hc_scale_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] d; logic s; int acc; } exp_t;
    exp_t q[$];

    int cyc = 0, tests = 0, fails = 0;
    int last_acc = -1;
    logic last_s = 1'b0, b2b = 1'b0, rnd_bp = 1'b0, ov_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 50000", cyc);
            $fatal(1);
        end
    end

    always @(posedge clk) if (rnd_bp) #1 out_ready = ($urandom_range(0, 3) != 0);

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int w16(int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // scale chains as plain integer arithmetic with 16-bit wrap per addition
    function automatic logic [15:0] model(logic [15:0] d, logic s);
        int x, a, b;
        x = int'($signed(d));
        if (s) begin
            a = w16(x + (x >>> 3));
            b = w16((x >>> 9) + (x >>> 11));
            a = w16(a + b);
            return 16'(a);
        end
        a = w16(x + (x >>> 2));
        b = w16((a >>> 4) + (x >>> 6));
        a = w16(a + b);
        a = w16((a >>> 5) + x);
        return 16'(a >>> 1);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                if (!ov_prev) check("latency", cyc - q[0].acc, q[0].s ? 4 : 5);
                check("out_data", int'($signed(out_data)), int'($signed(q[0].d)));
                check("out_sel", int'(out_sel), int'(q[0].s));
                if (!out_ready) begin
                    check("bp_in_ready", int'(in_ready), 0);
                    check("bp_busy", int'(busy), 1);
                end else begin
                    void'(q.pop_front());
                end
            end
        end
        ov_prev = out_valid;
    end

    // leaves in_valid high; caller drops it when the stream ends
    task automatic send(logic [15:0] d, logic s, logic [15:0] e);
        int n;
        exp_t it;
        in_valid = 1'b1; in_data = d; in_sel = s;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin n++; @(negedge clk); end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            it.d = e; it.s = s; it.acc = cyc;
            q.push_back(it);
            if (b2b) begin
                if (last_acc >= 0) check("cadence", cyc - last_acc, last_s ? 5 : 6);
                last_acc = cyc; last_s = s;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && n < 500) begin n++; @(negedge clk); end
        check("drain_timeout", int'(q.size() != 0 || busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] edges [6];
        logic [15:0] d;
        logic s;
        int n;
        edges = '{16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'h8001, 16'h4000};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;

        send(16'd4096, 1'b0, 16'd2134); in_valid = 1'b0; drain();
        send(16'd4096, 1'b1, 16'd4618); in_valid = 1'b0; drain();
        send(16'hF000, 1'b0, 16'hF7AA); in_valid = 1'b0; drain();
        send(16'hFFFF, 1'b0, 16'hFFFF); in_valid = 1'b0; drain();
        foreach (edges[i]) begin
            send(edges[i], 1'(i), model(edges[i], 1'(i))); in_valid = 1'b0; drain();
        end

        // backpressure: result held, input pulses ignored
        out_ready = 1'b0;
        send(16'd4096, 1'b0, 16'd2134); in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin n++; @(posedge clk); #1; end
        check("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1)); in_data = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_idle", int'(busy), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_queue_empty", q.size(), 0);
        @(posedge clk); #1;

        // reset while RUN is at step 2
        send(16'd4096, 1'b0, 16'd2134); in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_data", int'(out_data), 0);
        check("abort_busy", int'(busy), 0);
        @(posedge clk); #1;
        send(16'd4096, 1'b1, 16'd4618); in_valid = 1'b0; drain();

        // back-to-back with alternating select
        b2b = 1'b1; last_acc = -1;
        for (int i = 0; i < 6; i++) send(16'd4096, 1'(i), (i % 2) ? 16'd4618 : 16'd2134);
        in_valid = 1'b0; b2b = 1'b0;
        drain();

        // random operands under random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom); s = 1'($urandom_range(0, 1));
            send(d, s, model(d, s));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_bp = 1'b0; #2 out_ready = 1'b1;
        drain();

        check("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hc_scale_seq.md
Name: hc_scale_seq

Overview:
- Multi-cycle sequencer that multiplies a signed fixed-point operand by sinh(0.5) or cosh(0.5) using a single shared fixedAddSub adder (MODE=0, add).
- Each shift-add step of the constant-multiply chain runs in its own clock cycle, replacing the fully unrolled combinational adder chain.
- Sits between the range-reduction front end and the hyperbolic CORDIC core. Uses valid/ready handshakes on both sides.

Parameters:
- INT_WIDTH, default I_INT_WIDTH: integer bits of the operand.
- FRA_WIDTH, default I_FRA_WIDTH: fractional bits of the operand.
- SIGN_WIDTH, default I_SIGN_WIDTH: sign bits of the operand.
- DWIDTH, default IDWIDTH: total operand width, two's complement.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept (high only in IDLE and not in reset)
- in_data  in  DWIDTH  operand x
- in_sel  in  1  0 = scale by sinh(0.5), 1 = scale by cosh(0.5)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  DWIDTH  scaled result
- out_sel  out  1  in_sel captured with this result
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE, step=0, registers X/A/B=0, out_valid=0, out_data=0, out_sel=0. in_ready=0 while rst is high.
- Reset asserted mid-operation aborts the operation. The operand is discarded and no out_valid is produced.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid is high at the edge: X<=in_data, sel latched, step<=0, go to RUN.
  - RUN: one adder operation per cycle, chosen by (sel, step). Each result is written at the edge. On the last step go to DONE, otherwise step++.
  - DONE: out_valid=1; out_data and out_sel are held stable. When out_ready is high at the edge: out_valid<=0, go to IDLE.
- in_valid is ignored outside IDLE. No new operand is accepted in the same cycle a result drains; this gives one idle bubble.
- Adder: both operands come from the microcode; there is exactly one fixedAddSub instance. Shifts are arithmetic right shifts (>>>), truncating toward minus infinity.
- sinh program, 4 steps:
  - step 0: A = X + (X>>>2)
  - step 1: B = (A>>>4) + (X>>>6)
  - step 2: A = A + B
  - step 3: A = (A>>>5) + X
  - at entry to DONE: out_data = A>>>1
  - Net scale 0.52099609375.
- cosh program, 3 steps:
  - step 0: A = X + (X>>>3)
  - step 1: B = (X>>>9) + (X>>>11)
  - step 2: A = A + B
  - at entry to DONE: out_data = A
  - Net scale 1.12744140625.
- Latency, counted from the accept edge to the first cycle with out_valid=1: sinh 5 cycles, cosh 4 cycles. Throughput without backpressure: one result per 6 (sinh) or 5 (cosh) cycles.
- Overflow and wrap behaviour is exactly that of fixedAddSub at DWIDTH. Results are bit-exact with the equivalent unrolled chain.
- Backpressure: out_ready may stay low indefinitely. The result is held and in_ready stays 0.

Decomposition:
- Shared package hyperCord_pkg gains:
  - state enum (IDLE, RUN, DONE)
  - operand-source enum (SRC_X, SRC_A, SRC_B)
  - destination enum (DST_A, DST_B)
  - SINH_STEPS=4, COSH_STEPS=3
  - microcode word struct {srcA, shA, srcB, shB, dst, last}
- One sub-module, hc_scale_ucode: combinational ROM mapping (sel, step) to the microcode word.
- Top level holds the FSM, the X/A/B registers, the two barrel shifters and the fixedAddSub instance.

Test Plan:
All cases use DWIDTH=16, Q3.12 (1.0 = 4096).
- sinh, x=4096, out_ready held high → intermediates A=5120, B=384, A=5504, A=4268. out_data=2134, out_valid first high 5 cycles after the accept edge, out_sel=0.
- cosh, x=4096 → intermediates A=4608, B=10. out_data=4618, latency 4, out_sel=1.
- sinh, x=-4096 → out_data=-2134. sinh, x=-1 → out_data=-1 (truncation check).
- Backpressure: sinh x=4096 with out_ready low for 10 cycles → out_data stays 2134, in_ready=0 and busy=1 throughout; in_valid pulses in that window are ignored. Raising out_ready → IDLE in one cycle, in_ready=1 the next cycle.
- Reset in RUN at step 2 → next cycle IDLE, out_valid=0, out_data=0. A following cosh x=4096 gives 4618.
- Back-to-back: in_valid held high with alternating sel → results alternate 2134/4618 at the 6/5-cycle cadence, with no lost or duplicated transactions.
